// File: rtl/mod_secuenciador_calc_pkg.sv
// Shared types and constants for the calculator sequencer: FSM state encoding,
// ALU operation codes and the default datapath width.
package pkg_calculadora;

    localparam int N_BITS_DEF = 8;

    localparam logic [1:0] OP_SUMA  = 2'b00;
    localparam logic [1:0] OP_RESTA = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    typedef enum logic [2:0] {
        S_CARGA_A  = 3'd0,
        S_CARGA_B  = 3'd1,
        S_CARGA_OP = 3'd2,
        S_CALCULA  = 3'd3,
        S_MUESTRA  = 3'd4
    } estado_t;

endpackage

// File: rtl/mod_secuenciador_calc_detector_flanco.sv
// Button conditioner: 2-flop synchronizer plus rising-edge detector, one pulse per press.
// Pulses stay blocked after reset until the button has been seen released once.
module mod_detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic boton,
    output logic pulso
);

    logic       r_sinc1;
    logic       r_sinc2;
    logic       r_previo;
    logic       r_armado;
    logic [1:0] r_llenado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sinc1   <= 1'b0;
            r_sinc2   <= 1'b0;
            r_previo  <= 1'b0;
            r_armado  <= 1'b0;
            r_llenado <= 2'b00;
        end else begin
            r_sinc1   <= boton;
            r_sinc2   <= r_sinc1;
            r_previo  <= r_sinc2;
            r_llenado <= {r_llenado[0], 1'b1};
            // arm only once the synchronized level is real and low, so a button
            // held through reset release never fires
            if (r_llenado[1] && !r_sinc2) begin
                r_armado <= 1'b1;
            end
        end
    end

    assign pulso = r_armado & r_sinc2 & ~r_previo;

endmodule

// File: rtl/mod_secuenciador_calc.sv
// Calculator sequencer: captures A, B and op from switches, drives an external ALU and
// latches its result. Define SECUENCIADOR_ENCADENA_EN to chain the result into A.
//
// state      | meaning
// S_CARGA_A  | waiting for operand A
// S_CARGA_B  | waiting for operand B
// S_CARGA_OP | waiting for operation code
// S_CALCULA  | one cycle, latch ALU result
// S_MUESTRA  | result shown until next press
module mod_secuenciador_calc
    import pkg_calculadora::*;
#(
    parameter int n_bits = N_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [n_bits-1:0] valor_in,
    input  logic [1:0]        op_in,
    input  logic              boton_cargar,
    input  logic              boton_borrar,
    output logic [n_bits-1:0] alu_a,
    output logic [n_bits-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [n_bits-1:0] alu_resultado,
    output logic [n_bits-1:0] resultado,
    output logic              resultado_valido,
    output logic [2:0]        estado
);

    estado_t           r_estado;
    logic [n_bits-1:0] r_reg_a;
    logic [n_bits-1:0] r_reg_b;
    logic [1:0]        r_reg_op;
    logic [n_bits-1:0] r_resultado;
    logic              r_valido;

    estado_t           w_estado_sig;
    logic [n_bits-1:0] w_reg_a_sig;
    logic [n_bits-1:0] w_reg_b_sig;
    logic [1:0]        w_reg_op_sig;
    logic [n_bits-1:0] w_resultado_sig;
    logic              w_valido_sig;
    logic              w_cargar;
    logic              w_borrar;

    mod_detector_flanco u_det_cargar (
        .clk   (clk),
        .rst_n (rst_n),
        .boton (boton_cargar),
        .pulso (w_cargar)
    );

    mod_detector_flanco u_det_borrar (
        .clk   (clk),
        .rst_n (rst_n),
        .boton (boton_borrar),
        .pulso (w_borrar)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= S_CARGA_A;
            r_reg_a     <= '0;
            r_reg_b     <= '0;
            r_reg_op    <= '0;
            r_resultado <= '0;
            r_valido    <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_reg_a     <= w_reg_a_sig;
            r_reg_b     <= w_reg_b_sig;
            r_reg_op    <= w_reg_op_sig;
            r_resultado <= w_resultado_sig;
            r_valido    <= w_valido_sig;
        end
    end

    always_comb begin
        w_estado_sig    = r_estado;
        w_reg_a_sig     = r_reg_a;
        w_reg_b_sig     = r_reg_b;
        w_reg_op_sig    = r_reg_op;
        w_resultado_sig = r_resultado;
        w_valido_sig    = r_valido;
        if (w_borrar) begin
            w_estado_sig    = S_CARGA_A;
            w_reg_a_sig     = '0;
            w_reg_b_sig     = '0;
            w_reg_op_sig    = '0;
            w_resultado_sig = '0;
            w_valido_sig    = 1'b0;
        end else begin
            case (r_estado)
                S_CARGA_A: if (w_cargar) begin
                    w_reg_a_sig  = valor_in;
                    w_estado_sig = S_CARGA_B;
                end
                S_CARGA_B: if (w_cargar) begin
                    w_reg_b_sig  = valor_in;
                    w_estado_sig = S_CARGA_OP;
                end
                S_CARGA_OP: if (w_cargar) begin
                    w_reg_op_sig = op_in;
                    w_estado_sig = S_CALCULA;
                end
                S_CALCULA: begin
                    w_resultado_sig = alu_resultado;
                    w_valido_sig    = 1'b1;
                    w_estado_sig    = S_MUESTRA;
                end
                S_MUESTRA: if (w_cargar) begin
                    w_valido_sig = 1'b0;
`ifdef SECUENCIADOR_ENCADENA_EN
                    w_reg_a_sig  = r_resultado;
`else
                    w_reg_a_sig  = valor_in;
`endif
                    w_estado_sig = S_CARGA_B;
                end
                default: w_estado_sig = S_CARGA_A;
            endcase
        end
    end

    assign alu_a            = r_reg_a;
    assign alu_b            = r_reg_b;
    assign alu_op           = r_reg_op;
    assign resultado        = r_resultado;
    assign resultado_valido = r_valido;
    assign estado           = r_estado;

endmodule

// File: tb/tb_mod_secuenciador_calc.sv
// Bench for mod_secuenciador_calc: external ALU stand-in, press-level reference model
// and a result scoreboard checked whenever resultado_valido rises.
module tb_mod_secuenciador_calc;
    import pkg_calculadora::*;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] valor_in;
    logic [1:0]    op_in;
    logic          boton_cargar;
    logic          boton_borrar;
    logic [NB-1:0] alu_a;
    logic [NB-1:0] alu_b;
    logic [1:0]    alu_op;
    logic [NB-1:0] alu_resultado;
    logic [NB-1:0] resultado;
    logic          resultado_valido;
    logic [2:0]    estado;

    int n_cmp = 0;
    int n_err = 0;
    logic [NB-1:0] exp_q[$];

    int            m_fase;
    logic [NB-1:0] m_a, m_b, m_res;
    logic [1:0]    m_op;
    logic          m_val;

    mod_secuenciador_calc #(.n_bits(NB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valor_in         (valor_in),
        .op_in            (op_in),
        .boton_cargar     (boton_cargar),
        .boton_borrar     (boton_borrar),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_op           (alu_op),
        .alu_resultado    (alu_resultado),
        .resultado        (resultado),
        .resultado_valido (resultado_valido),
        .estado           (estado)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            OP_SUMA:  alu_resultado = alu_a + alu_b;
            OP_RESTA: alu_resultado = alu_a - alu_b;
            OP_AND:   alu_resultado = alu_a & alu_b;
            default:  alu_resultado = alu_a | alu_b;
        endcase
    end

    task automatic check(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nombre, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] ref_calc(input int a, input int b, input int o);
        int r;
        case (o)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[NB-1:0];
    endfunction

    task automatic model_borrar();
        m_fase = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_val = 0;
    endtask

    task automatic model_cargar(input logic [NB-1:0] v, input logic [1:0] o);
        case (m_fase)
            0: begin m_a = v; m_fase = 1; end
            1: begin m_b = v; m_fase = 2; end
            2: begin
                m_op = o;
                m_res = ref_calc(int'(m_a), int'(m_b), int'(o));
                m_val = 1'b1;
                m_fase = 4;
                exp_q.push_back(m_res);
            end
            default: begin
                m_val = 1'b0;
`ifdef SECUENCIADOR_ENCADENA_EN
                m_a = m_res;
`else
                m_a = v;
`endif
                m_fase = 1;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".estado"}, 32'(estado), 32'(m_fase));
        check({tag, ".valido"}, 32'(resultado_valido), 32'(m_val));
        check({tag, ".resultado"}, 32'(resultado), 32'(m_res));
        check({tag, ".alu_a"}, 32'(alu_a), 32'(m_a));
        check({tag, ".alu_b"}, 32'(alu_b), 32'(m_b));
        check({tag, ".alu_op"}, 32'(alu_op), 32'(m_op));
    endtask

    task automatic press(input logic c, input logic b, input int hold);
        @(negedge clk);
        boton_cargar = c;
        boton_borrar = b;
        repeat (hold) @(negedge clk);
        boton_cargar = 1'b0;
        boton_borrar = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cargar(input logic [NB-1:0] v, input logic [1:0] o, input int hold);
        valor_in = v;
        op_in    = o;
        model_cargar(v, o);
        press(1'b1, 1'b0, hold);
        valor_in = NB'($urandom);
        op_in    = 2'($urandom);
    endtask

    task automatic borrar();
        model_borrar();
        press(1'b0, 1'b1, 2);
    endtask

    // scoreboard monitor
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && resultado_valido && !mon_prev) begin
            if (exp_q.size() == 0) begin
                check("sb.unexpected", 32'(resultado), 32'hFFFF_FFFF);
            end else begin
                check("sb.resultado", 32'(resultado), 32'(exp_q.pop_front()));
            end
        end
        mon_prev <= resultado_valido;
    end

    initial begin
        rst_n = 1'b0; valor_in = '0; op_in = '0;
        boton_cargar = 1'b0; boton_borrar = 1'b0;
        model_borrar();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all("reset");

        // A=5 with edge-accurate timing: effect on the 3rd edge
        valor_in = 8'd5;
        model_cargar(8'd5, 2'd0);
        @(negedge clk);
        boton_cargar = 1'b1;
        @(posedge clk); #1 check("lat.edge1", 32'(estado), 32'd0);
        @(posedge clk); #1 check("lat.edge2", 32'(estado), 32'd0);
        @(posedge clk); #1 check("lat.edge3", 32'(estado), 32'd1);
        check("lat.alu_a", 32'(alu_a), 32'd5);
        @(negedge clk);
        boton_cargar = 1'b0;
        repeat (4) @(negedge clk);
        cargar(8'd3, 2'd0, 2);
        cargar(8'd0, 2'd0, 1);
        check("suma.resultado", 32'(resultado), 32'h08);
        check_all("suma");

        cargar(8'd1, 2'd0, 1);
        cargar(8'd2, 2'd0, 1);
        cargar(8'd0, 2'd3, 1);
`ifdef SECUENCIADOR_ENCADENA_EN
        check("cadena.resultado", 32'(resultado), 32'h0A);
`else
        check("cadena.resultado", 32'(resultado), 32'h03);
`endif
        check_all("cadena");

        borrar();
        check_all("borrar1");
        cargar(8'd3, 2'd0, 1);
        cargar(8'd5, 2'd0, 1);
        cargar(8'd0, 2'd1, 1);
        check("resta.resultado", 32'(resultado), 32'hFE);
        check_all("resta");

        borrar();
        cargar(8'h5A, 2'd0, 50);
        check("hold50.estado", 32'(estado), 32'd1);
        check_all("hold50");

        cargar(8'h33, 2'd0, 1);
        op_in = 2'd2;
        model_borrar();
        press(1'b1, 1'b1, 2);
        check_all("prioridad");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                borrar();
            end else begin
                cargar(NB'($urandom), 2'($urandom), int'($urandom_range(1, 4)));
            end
            check_all("rnd");
        end

        borrar();
        cargar(8'h10, 2'd0, 1);
        cargar(8'h20, 2'd0, 1);
        cargar(8'h00, 2'd3, 1);
        check_all("premuestra");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_borrar();
        check_all("rst_async");

        boton_cargar = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("held_release.estado", 32'(estado), 32'd0);
        boton_cargar = 1'b0;
        repeat (5) @(negedge clk);
        check_all("held_release");
        cargar(8'h77, 2'd0, 1);
        check_all("after_release");

        repeat (4) @(negedge clk);
        check("sb.pendientes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_secuenciador_calc.md
MOD_SECUENCIADOR_CALC -- requirements
Module: mod_secuenciador_calc

Interface
REQ-001 The block SHALL have parameter n_bits, default 8, giving the operand and result width.
REQ-002 The block SHALL have clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have valor_in, input, n_bits, the operand value from the switches.
REQ-005 The block SHALL have op_in, input, 2, the operation code from the switches.
REQ-006 The block SHALL have boton_cargar, input, 1, the raw load/advance button, asynchronous to clk.
REQ-007 The block SHALL have boton_borrar, input, 1, the raw clear button, asynchronous to clk.
REQ-008 The block SHALL have alu_a, alu_b, alu_op, outputs, n_bits/n_bits/2, driven to the ALU operand and operation inputs.
REQ-009 The block SHALL have alu_resultado, input, n_bits, the ALU result fed back.
REQ-010 The block SHALL have resultado, output, n_bits, the latched result for the display.
REQ-011 The block SHALL have resultado_valido, output, 1, asserted while resultado holds a fresh result.
REQ-012 The block SHALL have estado, output, 3, the FSM state encoding for the LEDs.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer followed by rising-edge detection, giving one single-cycle pulse per press regardless of hold time.
REQ-014 An action SHALL take effect on the 3rd rising clk edge, counting the first edge that samples the button high.
REQ-015 The FSM SHALL have the states S_CARGA_A=0, S_CARGA_B=1, S_CARGA_OP=2, S_CALCULA=3 and S_MUESTRA=4.
REQ-016 In S_CARGA_A, a cargar pulse SHALL load reg_a<=valor_in and go to S_CARGA_B.
REQ-017 In S_CARGA_B, a cargar pulse SHALL load reg_b<=valor_in and go to S_CARGA_OP.
REQ-018 In S_CARGA_OP, a cargar pulse SHALL load reg_op<=op_in and go to S_CALCULA.
REQ-019 S_CALCULA SHALL last exactly 1 cycle, latch resultado<=alu_resultado, set resultado_valido=1 and go to S_MUESTRA unconditionally.
REQ-020 In S_MUESTRA, resultado and resultado_valido SHALL hold until a cargar or borrar pulse.
REQ-021 In S_MUESTRA, a cargar pulse SHALL clear resultado_valido and act as defined in REQ-030/031.
REQ-022 alu_a, alu_b and alu_op SHALL equal reg_a, reg_b and reg_op combinationally at all times.
REQ-023 All arithmetic SHALL be performed by the external ALU, and the result SHALL be taken modulo 2^n_bits with no carry or overflow output.
REQ-024 A borrar pulse SHALL, in any state, clear reg_a, reg_b, reg_op, resultado and resultado_valido, and go to S_CARGA_A.
REQ-025 A borrar pulse SHALL take priority over a cargar pulse detected in the same cycle.
REQ-026 cargar pulses arriving while in S_CALCULA SHALL be discarded.
REQ-027 Changes on valor_in or op_in outside the capturing cycle SHALL have no effect.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force the state to S_CARGA_A and all registers, resultado, resultado_valido and the synchronizer/edge flops to 0, independent of clk.
REQ-029 On release of rst_n, no pulse SHALL be generated for a button already held at release; a new press is required.

Configuration
REQ-030 With macro SECUENCIADOR_ENCADENA_EN defined, a cargar pulse in S_MUESTRA SHALL load reg_a<=resultado (accumulator chaining) and go to S_CARGA_B.
REQ-031 With SECUENCIADOR_ENCADENA_EN undefined, a cargar pulse in S_MUESTRA SHALL load reg_a<=valor_in and go to S_CARGA_B.

Structure
REQ-032 Package pkg_calculadora SHALL hold typedef enum estado_t (3-bit), the op constants OP_SUMA=00, OP_RESTA=01, OP_AND=10 and OP_OR=11, and the constant N_BITS_DEF=8.
REQ-033 Sub-module mod_detector_flanco, containing the synchronizer and edge detector, SHALL be instantiated once per button.

Verification
REQ-034 Press sequence A=5, B=3, op=00 -> resultado=8 and resultado_valido=1 one cycle after the op capture, with estado=4.
REQ-035 Press sequence A=3, B=5, op=01 -> resultado=0xFE.
REQ-036 With SECUENCIADOR_ENCADENA_EN defined, after resultado=8: press cargar, B=2, op=11 -> resultado=0x0A; with the macro undefined and valor_in=1, the same presses -> resultado=0x03.
REQ-037 cargar held high for 50 cycles in S_CARGA_A -> exactly one capture and estado=1.
REQ-038 borrar and cargar pulses in the same cycle in S_CARGA_OP -> estado=0, all registers 0 and no op capture.
REQ-039 rst_n pulled low mid-cycle in S_MUESTRA -> outputs 0 and estado=0 before the next clk edge.
